event_out_buffer: RTL and testbench

- Output stage directly downstream of the event filter.
- Captures each registered event (x, y, t, p; 2 bits per field) into a small synchronous FIFO.
- Presents the events to the chip output pins over a valid/ready byte interface, so the filter is never back-pressured.
- Counts events that are lost because the FIFO is full, and exposes that count as a saturating diagnostic.

---
 rtl/event_pkg.sv | 39 +++
 rtl/sync_fifo.sv | 83 ++++++++
 rtl/event_out_buffer.sv | 90 +++++++++
 tb/tb_event_out_buffer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/event_pkg.sv
`default_nettype none
// ============================================================================
// Module      : event_pkg
// Description : Shared definitions for the event output path. Holds the event
//               field/word widths, the bit positions of each field inside a
//               packed event word, and the packing helper ev_pack().
//               Packed layout, MSB first: {x[1:0], y[1:0], t[1:0], p[1:0]}.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package event_pkg;

  localparam int EV_FIELD_W = 2;
  localparam int EV_WORD_W  = 4 * EV_FIELD_W;

  // Field positions inside a packed event word; x sits in the MSBs.
  localparam int X_MSB = 7;
  localparam int X_LSB = 6;
  localparam int Y_MSB = 5;
  localparam int Y_LSB = 4;
  localparam int T_MSB = 3;
  localparam int T_LSB = 2;
  localparam int P_MSB = 1;
  localparam int P_LSB = 0;

  typedef logic [EV_FIELD_W-1:0] ev_field_t;
  typedef logic [EV_WORD_W-1:0]  ev_word_t;

  function automatic ev_word_t ev_pack(
    input ev_field_t x,
    input ev_field_t y,
    input ev_field_t t,
    input ev_field_t p
  );
    return {x, y, t, p};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : First-word-fall-through synchronous FIFO. rdata always shows
//               the entry at the read pointer; the caller qualifies it with
//               level. Empty/full come from the occupancy counter, so the
//               pointers may simply wrap.
//               Contract: the caller never pushes while full without a pop,
//               and never pops while empty.
// Ports       : clk   - rising-edge clock
//               rst   - synchronous active-high reset (pointers, level)
//               push  - write wdata at the write pointer this cycle
//               pop   - retire the head entry this cycle
//               wdata - word to write
//               rdata - head entry (raw, not zeroed when empty)
//               level - number of occupied entries
//               full  - level == DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] C_DEPTH = LW'(DEPTH);

  // Storage is intentionally left out of reset; level gates its visibility.
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q,  level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // A push while full is only legal together with a pop; the head is read
  // combinationally before this edge, so overwriting that slot is safe.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign level = level_q;
  assign full  = (level_q == C_DEPTH);

endmodule
`default_nettype wire

// File: rtl/event_out_buffer.sv
`default_nettype none
// ============================================================================
// Module      : event_out_buffer
// Description : Output stage behind the event filter. Packs each incoming
//               event into a byte, queues it in a small FIFO and presents it
//               on a valid/ready byte interface. The filter is never stalled:
//               an event that finds the FIFO full (and no pop in the same
//               cycle) is discarded and counted in a saturating counter.
// Ports       : clk        - rising-edge clock
//               rst        - synchronous active-high reset
//               in_valid   - event present on in_x/in_y/in_t/in_p
//               in_x/y/t/p - 2-bit event fields
//               out_valid  - out_data holds a valid event
//               out_ready  - consumer takes out_data this cycle
//               out_data   - packed {x, y, t, p}, 8'h00 when empty
//               level      - FIFO occupancy
//               full       - level == DEPTH
//               drop_count - saturating count of discarded events
// Revision    : 1.0 - initial release
// ============================================================================
module event_out_buffer
  import event_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [EV_FIELD_W-1:0]   in_x,
  input  logic [EV_FIELD_W-1:0]   in_y,
  input  logic [EV_FIELD_W-1:0]   in_t,
  input  logic [EV_FIELD_W-1:0]   in_p,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EV_WORD_W-1:0]    out_data,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    full
  ,
  output logic [DROP_W-1:0]       drop_count
);

  logic           push;
  logic           pop;
  logic           drop;
  ev_word_t       wdata;
  ev_word_t       fifo_rdata;

  logic [DROP_W-1:0] drop_count_q, drop_count_d;

  // out_valid depends only on the registered level, so pop never sees in_*.
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  // A full FIFO can still accept when the head leaves in the same cycle.
  assign push      = in_valid && (!full || pop);
  assign drop      = in_valid && !push;

  assign wdata     = ev_pack(in_x, in_y, in_t, in_p);

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EV_WORD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (fifo_rdata),
    .level (level),
    .full  (full)
  );

  // Storage is not reset, so hide stale contents while empty.
  assign out_data = out_valid ? fifo_rdata : '0;

  always_comb begin
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != '1)) drop_count_d = drop_count_q + DROP_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) drop_count_q <= '0;
    else     drop_count_q <= drop_count_d;
  end

  assign drop_count = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_event_out_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_event_out_buffer
// Description : Self-checking bench for event_out_buffer. Two instances share
//               all inputs: one with default parameters and one with a 2-bit
//               drop counter. A queue-based reference model predicts every
//               output after each clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_event_out_buffer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] in_x, in_y, in_t, in_p;
  logic       out_ready;

  logic       out_valid,  out_valid_2;
  logic [7:0] out_data,   out_data_2;
  logic [2:0] level,      level_2;
  logic       full,       full_2;
  logic [7:0] drop_count;
  logic [1:0] drop_count_2;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the FIFO contents in arrival order and an unbounded
  // count of discarded events.
  logic [7:0] model_q[$];
  int         model_drops;

  always #5 clk = ~clk;

  event_out_buffer #(.DEPTH(DEPTH), .DROP_W(8)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_t       (in_t),
    .in_p       (in_p),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .level      (level),
    .full       (full),
    .drop_count (drop_count)
  );

  event_out_buffer #(.DEPTH(DEPTH), .DROP_W(2)) u_dut_d2 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_t       (in_t),
    .in_p       (in_p),
    .out_valid  (out_valid_2),
    .out_ready  (out_ready),
    .out_data   (out_data_2),
    .level      (level_2),
    .full       (full_2),
    .drop_count (drop_count_2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data();
    return (model_q.size() != 0) ? 32'(model_q[0]) : 32'h0;
  endfunction

  function automatic logic [31:0] sat(input int v, input int max);
    return (v > max) ? 32'(max) : 32'(v);
  endfunction

  // Apply one clock cycle of rules to the model, using inputs seen at the edge.
  task automatic model_update(input logic r, input logic v, input logic [7:0] w, input logic rdy);
    bit do_pop, do_push;
    if (r) begin
      model_q.delete();
      model_drops = 0;
    end else begin
      do_pop  = (model_q.size() != 0) && rdy;
      do_push = v && ((model_q.size() < DEPTH) || do_pop);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(w);
      else if (v) model_drops++;
    end
  endtask

  task automatic check_all();
    check("out_valid",  32'(out_valid),    32'(model_q.size() != 0));
    check("out_data",   32'(out_data),     exp_data());
    check("level",      32'(level),        32'(model_q.size()));
    check("full",       32'(full),         32'(model_q.size() == DEPTH));
    check("drop_count", 32'(drop_count),   sat(model_drops, 255));
    check("drop_count_d2", 32'(drop_count_2), sat(model_drops, 3));
    check("out_data_d2",   32'(out_data_2),   exp_data());
    check("level_d2",      32'(level_2),      32'(model_q.size()));
  endtask

  // One cycle: drive inputs, confirm the outputs ignore the new inputs before
  // the edge, clock, advance the model, then compare everything.
  task automatic step(input logic r, input logic v, input logic [1:0] x, input logic [1:0] y,
                      input logic [1:0] t, input logic [1:0] p, input logic rdy);
    rst = r; in_valid = v; in_x = x; in_y = y; in_t = t; in_p = p; out_ready = rdy;
    #2;
    check("pre_edge_valid", 32'(out_valid), 32'(model_q.size() != 0));
    check("pre_edge_data",  32'(out_data),  exp_data());
    @(posedge clk);
    model_update(r, v, {x, y, t, p}, rdy);
    #1;
    check_all();
  endtask

  task automatic step_rand(input logic r, input int v_pct, input int rdy_pct);
    step(r, ($urandom_range(0, 99) < v_pct),
         2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
         ($urandom_range(0, 99) < rdy_pct));
  endtask

  initial begin
    int rdy_pct;
    model_drops = 0;
    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_t = '0; in_p = '0; out_ready = 1'b0;
    @(posedge clk);
    model_update(1'b1, 1'b0, 8'h00, 1'b0);
    #1;

    // Reset then idle.
    step(1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    check("reset_data_zero", 32'(out_data), 32'h0);
    check("reset_drop_zero", 32'(drop_count), 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);

    // Single event, held with out_ready low, then consumed.
    step(1'b0, 1'b1, 2'd3, 2'd1, 2'd2, 2'd1, 1'b0);
    check("single_pack", 32'(out_data), 32'hD9);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1);
    check("single_drained", 32'(out_valid), 32'h0);
    // out_ready while empty has no effect.
    step(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1);

    // Fill and overflow: six events into four slots.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 2'(i % 4), 1'b0);
    check("overflow_drops", 32'(drop_count), 32'd2);
    check("overflow_full",  32'(full), 32'd1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 4; i++) step_rand(1'b0, 100, 0);
    for (int i = 0; i < 3; i++) step_rand(1'b0, 100, 100);
    check("full_pushpop_level", 32'(level), 32'd4);

    // Hold full and keep pushing: 2-bit counter must stick at 3.
    for (int i = 0; i < 6; i++) step_rand(1'b0, 100, 0);
    check("sat_d2", 32'(drop_count_2), 32'd3);

    // Reset mid-stream.
    step(1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) step_rand(1'b0, 100, 0);
    step_rand(1'b1, 100, 100);
    check("midreset_valid", 32'(out_valid), 32'h0);

    // Ten push/pop pairs walk the pointers around the ring.
    for (int i = 0; i < 10; i++) begin
      step_rand(1'b0, 100, 0);
      step_rand(1'b0, 0, 100);
    end
    for (int i = 0; i < 10; i++) step_rand(1'b0, 100, 100);
    for (int i = 0; i < 3; i++) step_rand(1'b0, 0, 100);

    // Random traffic with changing back-pressure and rare resets.
    for (int blk = 0; blk < 8; blk++) begin
      rdy_pct = (blk % 2 == 0) ? 25 : 85;
      for (int i = 0; i < 50; i++) step_rand(($urandom_range(0, 79) == 0), 70, rdy_pct);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
